// File: rtl/wb_interconnect_tgt_port.sv
// rtl/wb_interconnect_tgt_port.sv - Wishbone interconnect target-side port
//
// Purpose:
//   One instance sits in front of each target. It raises an arbiter request for
//   every initiator holding CYC, latches the arbiter's grant, muxes the owning
//   initiator onto the single target bus and routes ack/err/rdata back. A
//   watchdog turns a target beat that hangs for TIMEOUT cycles into an error.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   i_cyc/i_stb/i_we          per-initiator bus controls
//   i_adr/i_dat_w/i_sel       packed per-initiator address, write data, byte selects
//   o_ack/o_err               per-initiator completion
//   o_dat_r                   read data shared by all initiators
//   arb_req/arb_gnt           request to / grant from the arbiter
//   t_cyc/t_stb/t_we          target bus controls
//   t_adr/t_dat_w/t_sel       target address, write data, byte selects
//   t_dat_r/t_ack/t_err       target read data and completion

module wb_interconnect_tgt_port #(
    parameter int N_INIT  = 2,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_INIT-1:0]           i_cyc,
    input  logic [N_INIT-1:0]           i_stb,
    input  logic [N_INIT-1:0]           i_we,
    input  logic [N_INIT*ADR_W-1:0]     i_adr,
    input  logic [N_INIT*DAT_W-1:0]     i_dat_w,
    input  logic [N_INIT*DAT_W/8-1:0]   i_sel,
    output logic [N_INIT-1:0]           o_ack,
    output logic [N_INIT-1:0]           o_err,
    output logic [DAT_W-1:0]            o_dat_r,
    output logic [N_INIT-1:0]           arb_req,
    input  logic [N_INIT-1:0]           arb_gnt,
    output logic                        t_cyc,
    output logic                        t_stb,
    output logic                        t_we,
    output logic [ADR_W-1:0]            t_adr,
    output logic [DAT_W-1:0]            t_dat_w,
    output logic [DAT_W/8-1:0]          t_sel,
    input  logic [DAT_W-1:0]            t_dat_r,
    input  logic                        t_ack,
    input  logic                        t_err
);

    localparam int SEL_W = DAT_W / 8;
    localparam int IDX_W = (N_INIT > 1) ? $clog2(N_INIT) : 1;
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT
    } state_t;

    state_t             state, state_nxt;
    logic [N_INIT-1:0]  sel_r, sel_nxt;
    logic [IDX_W-1:0]   idx_r, idx_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;

    logic [N_INIT-1:0]  gnt_hit;
    logic [IDX_W-1:0]   gnt_idx;

    logic               own_cyc, own_stb, own_we;
    logic [ADR_W-1:0]   own_adr;
    logic [DAT_W-1:0]   own_dat_w;
    logic [SEL_W-1:0]   own_sel;
    logic               beat_stb;
    logic               beat_pending;
    logic               tmo_fire;

    // Requests follow CYC alone; STB only qualifies beats once the grant is held.
    assign arb_req = i_cyc;
    assign gnt_hit = arb_gnt & i_cyc;

    // Lowest set bit wins: scanning downwards lets the last match be the lowest index.
    always_comb begin
        gnt_idx = '0;
        for (int k = N_INIT - 1; k >= 0; k--) begin
            if (gnt_hit[k]) gnt_idx = IDX_W'(k);
        end
    end

    // Owner mux, driven by the latched index.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        own_we    = 1'b0;
        own_adr   = '0;
        own_dat_w = '0;
        own_sel   = '0;
        for (int k = 0; k < N_INIT; k++) begin
            if (IDX_W'(k) == idx_r) begin
                own_cyc   = i_cyc[k];
                own_stb   = i_stb[k];
                own_we    = i_we[k];
                own_adr   = i_adr[k*ADR_W +: ADR_W];
                own_dat_w = i_dat_w[k*DAT_W +: DAT_W];
                own_sel   = i_sel[k*SEL_W +: SEL_W];
            end
        end
    end

    assign beat_stb     = own_cyc & own_stb;
    assign beat_pending = (state == ACTIVE) & beat_stb & ~t_ack & ~t_err;
    // A response on the last watchdog cycle clears beat_pending, so it beats the abort.
    assign tmo_fire     = (TIMEOUT > 0) && beat_pending && (tmo_cnt == TMO_LAST);

    always_comb begin
        t_cyc   = 1'b0;
        t_stb   = 1'b0;
        t_we    = 1'b0;
        t_adr   = '0;
        t_dat_w = '0;
        t_sel   = '0;
        o_ack   = '0;
        o_err   = '0;
        o_dat_r = '0;
        case (state)
            ACTIVE: begin
                t_cyc   = own_cyc;
                t_stb   = beat_stb;
                t_we    = own_we;
                t_adr   = own_adr;
                t_dat_w = own_dat_w;
                t_sel   = own_sel;
                o_ack   = (t_ack & beat_stb) ? sel_r : '0;
                o_err   = (t_err & beat_stb) ? sel_r : '0;
                o_dat_r = t_dat_r;
            end
            ABORT: begin
                o_err = sel_r;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_r;
        idx_nxt   = idx_r;
        tmo_nxt   = '0;
        case (state)
            IDLE: begin
                if (|gnt_hit) begin
                    sel_nxt   = N_INIT'(1) << gnt_idx;
                    idx_nxt   = gnt_idx;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!own_cyc) begin
                    // Owner released the bus, possibly mid-beat: the beat is abandoned.
                    state_nxt = IDLE;
                end else if (tmo_fire) begin
                    state_nxt = ABORT;
                end else if (beat_pending && (TIMEOUT > 0)) begin
                    tmo_nxt = (tmo_cnt == TMO_SAT) ? tmo_cnt : tmo_cnt + TMO_W'(1);
                end
            end
            ABORT: begin
                state_nxt = own_cyc ? ACTIVE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_r   <= '0;
            idx_r   <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sel_r   <= sel_nxt;
            idx_r   <= idx_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

endmodule
